// File: rtl/vrom_rr_arbiter.sv
// ---------------------------------------------------------------------------
// vrom_rr_arbiter
//   Lets NUM_REQ requesters share the single read port of one VRom instance.
//   Requests are served round-robin, with at most one read in flight. Each
//   requester sees a valid/ready address handshake and later a one-cycle
//   response strobe that qualifies the shared rsp_data bus.
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   reset      in   synchronous active-high reset
//   req_valid  in   [NUM_REQ]            per-requester read request
//   req_addr   in   [NUM_REQ*ADDR_WIDTH] per-requester address, slice i = requester i
//   req_ready  out  [NUM_REQ]            one-hot grant (handshake = valid & ready)
//   rsp_valid  out  [NUM_REQ]            one-hot single-cycle strobe to the read owner
//   rsp_data   out  [DATA_LEN]           registered ROM word, valid while rsp_valid != 0
//   busy       out  read in flight (WAIT state)
//   rom_addr   out  [ADDR_WIDTH]         registered address to the VRom
//   rom_data   in   [DATA_LEN]           VRom read data
// ---------------------------------------------------------------------------
module vrom_rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_LEN    = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_LEN-1:0]           rsp_data,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_LEN-1:0]           rom_data
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ROM_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_LEN-1:0]    rsp_data_q, rsp_data_d;

    // scan_idx[k] is the requester examined k-th in round-robin order,
    // i.e. (ptr + k) mod NUM_REQ without needing a divider.
    logic [PTR_W-1:0]       scan_idx [NUM_REQ];
    logic [ADDR_WIDTH-1:0]  addr_slice [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
            logic [PTR_W:0] sum;
            assign sum = {1'b0, ptr_q} + (PTR_W+1)'(gi);
            assign scan_idx[gi] = (sum >= (PTR_W+1)'(NUM_REQ))
                                ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ))
                                : PTR_W'(sum);
            assign addr_slice[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    logic                   grant_found;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_en;

    // Walk the scan order backwards so the earliest requesting position
    // is the last assignment and therefore wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[scan_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[k];
            end
        end
    end

    // RESP may grant in the same cycle the response is delivered, which
    // gives a back-to-back period of ROM_LATENCY+1 cycles.
    assign grant_en  = grant_found && !reset && (state_q != ST_WAIT);
    assign req_ready = grant_en ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        rom_addr_d  = rom_addr_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // cnt==1 marks the edge at which rom_data is valid for rom_addr_q
                if (cnt_q == CNT_W'(1)) begin
                    rsp_data_d  = rom_data;
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    state_d     = ST_RESP;
                end
            end
            default: begin
                if (grant_en) begin
                    rom_addr_d = addr_slice[grant_idx];
                    owner_d    = grant_idx;
                    ptr_d      = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
                    cnt_d      = CNT_W'(ROM_LATENCY);
                    state_d    = ST_WAIT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            rom_addr_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            rom_addr_q  <= rom_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rom_addr  = rom_addr_q;
    assign busy      = (state_q == ST_WAIT);

endmodule

// File: tb/tb_vrom_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vrom_rr_arbiter
//   Drives two arbiter instances (ROM_LATENCY 1 and 3) with the same stimulus
//   and compares every cycle against a transaction-level reference: a read
//   granted in cycle T answers in cycle T+1+L with ROM word[addr], and the
//   port is free again in that response cycle. ROM word[a] = 8'h11*a.
// ---------------------------------------------------------------------------
module tb_vrom_rr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [11:0] req_addr;

    logic [3:0]  req_ready_w [2];
    logic [3:0]  rsp_valid_w [2];
    logic [7:0]  rsp_data_w  [2];
    logic        busy_w      [2];
    logic [2:0]  rom_addr_w  [2];
    logic [7:0]  rom_data_w  [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat [2] = '{1, 3};

    // reference model state, one set per instance
    int         m_ptr      [2];
    bit         m_infl     [2];
    int         m_resp_cyc [2];
    int         m_owner    [2];
    logic [2:0] m_addr     [2];
    logic [2:0] m_rom_addr [2];

    int grant_log [$];

    function automatic logic [7:0] rom_word(input logic [2:0] a);
        return 8'h11 * {5'b0, a};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 1 : 3;
            logic [2:0] dly [3];
            always @(posedge clk) begin
                dly[0] <= rom_addr_w[gi];
                dly[1] <= dly[0];
                dly[2] <= dly[1];
            end
            if (L == 1) begin : g_comb
                assign rom_data_w[gi] = rom_word(rom_addr_w[gi]);
            end else begin : g_pipe
                assign rom_data_w[gi] = rom_word(dly[L-2]);
            end

            vrom_rr_arbiter #(
                .NUM_REQ     (4),
                .ADDR_WIDTH  (3),
                .DATA_LEN    (8),
                .ROM_LATENCY (L)
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .req_valid (req_valid),
                .req_addr  (req_addr),
                .req_ready (req_ready_w[gi]),
                .rsp_valid (rsp_valid_w[gi]),
                .rsp_data  (rsp_data_w[gi]),
                .busy      (busy_w[gi]),
                .rom_addr  (rom_addr_w[gi]),
                .rom_data  (rom_data_w[gi])
            );
        end
    endgenerate

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: apply inputs, check every output of both instances
    // against the model, then advance the model across the coming edge.
    task automatic step(input logic rst, input logic [3:0] v, input logic [11:0] a);
        bit         free;
        int         g;
        logic [3:0] exp_ready;
        logic [3:0] exp_rsp;
        @(negedge clk);
        reset     = rst;
        req_valid = v;
        req_addr  = a;
        #1;
        for (int k = 0; k < 2; k++) begin
            free = !m_infl[k] || (cyc == m_resp_cyc[k]);
            g = -1;
            for (int j = 0; j < 4; j++)
                if (g < 0 && v[(m_ptr[k] + j) % 4]) g = (m_ptr[k] + j) % 4;
            exp_ready = (!rst && free && g >= 0) ? 4'(1 << g) : 4'b0;
            exp_rsp   = (m_infl[k] && cyc == m_resp_cyc[k]) ? 4'(1 << m_owner[k]) : 4'b0;

            check_val($sformatf("req_ready[i%0d]", k), 32'(req_ready_w[k]), 32'(exp_ready));
            check_val($sformatf("rsp_valid[i%0d]", k), 32'(rsp_valid_w[k]), 32'(exp_rsp));
            if (exp_rsp != 4'b0)
                check_val($sformatf("rsp_data[i%0d]", k), 32'(rsp_data_w[k]), 32'(rom_word(m_addr[k])));
            check_val($sformatf("busy[i%0d]", k), 32'(busy_w[k]),
                      32'(m_infl[k] && cyc < m_resp_cyc[k]));
            check_val($sformatf("rom_addr[i%0d]", k), 32'(rom_addr_w[k]), 32'(m_rom_addr[k]));

            if (req_ready_w[k] != 4'b0) begin
                for (int j = 0; j < 4; j++) begin
                    if (req_ready_w[k][j]) begin
                        $display("[TB] cycle %0d inst%0d grant req%0d addr %0d",
                                 cyc, k, j, a[j*3 +: 3]);
                        if (k == 0) grant_log.push_back(j);
                    end
                end
            end

            if (rst) begin
                m_ptr[k]      = 0;
                m_infl[k]     = 1'b0;
                m_rom_addr[k] = 3'd0;
            end else begin
                if (free) m_infl[k] = 1'b0;
                if (free && g >= 0) begin
                    m_infl[k]     = 1'b1;
                    m_resp_cyc[k] = cyc + 1 + lat[k];
                    m_owner[k]    = g;
                    m_addr[k]     = a[g*3 +: 3];
                    m_rom_addr[k] = a[g*3 +: 3];
                    m_ptr[k]      = (g + 1) % 4;
                end
            end
        end
        cyc++;
    endtask

    task automatic check_log(input string tag, input int exp [$]);
        check_val({tag, "_count"}, 32'(grant_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
            check_val($sformatf("%s_grant%0d", tag, i), 32'(grant_log[i]), 32'(exp[i]));
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_infl[k] = 1'b0; m_resp_cyc[k] = 0;
            m_owner[k] = 0; m_addr[k] = 3'd0; m_rom_addr[k] = 3'd0;
        end
        reset     = 1'b1;
        req_valid = 4'b0;
        req_addr  = 12'b0;
        @(posedge clk);

        // reset held with every requester asking: nothing may be granted
        step(1'b1, 4'hF, 12'hFFF);
        step(1'b1, 4'hF, 12'hFFF);

        // single read, latency 1: rom_addr at T+1, response at T+2
        step(1'b0, 4'b0001, 12'd3);
        step(1'b0, 4'b0000, 12'd0);
        check_val("t2_rom_addr", 32'(rom_addr_w[0]), 32'd3);
        step(1'b0, 4'b0000, 12'd0);
        check_val("t2_rsp_valid", 32'(rsp_valid_w[0]), 32'b0001);
        check_val("t2_rsp_data", 32'(rsp_data_w[0]), 32'h33);

        // all four requesting continuously, addr = i+4
        step(1'b1, 4'b0000, 12'd0);
        grant_log.delete();
        for (int i = 0; i < 10; i++) step(1'b0, 4'hF, {3'd7, 3'd6, 3'd5, 3'd4});
        step(1'b0, 4'b0000, 12'd0);
        check_log("t3", '{0, 1, 2, 3, 0});

        // req 2 alone moves ptr to 3; then 1 and 3 together: 3 first, then 1
        step(1'b1, 4'b0000, 12'd0);
        grant_log.delete();
        step(1'b0, 4'b0100, 12'd0);
        step(1'b0, 4'b0000, 12'd0);
        step(1'b0, 4'b0000, 12'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1010, {3'd1, 3'd2, 3'd3, 3'd0});
        step(1'b0, 4'b0000, 12'd0);
        check_log("t4", '{2, 3, 1});

        // reset while a read of addr 7 is in flight: it must vanish
        step(1'b1, 4'b0000, 12'd0);
        step(1'b0, 4'b0010, {3'd0, 3'd0, 3'd7, 3'd0});
        step(1'b1, 4'b0000, 12'd0);
        step(1'b0, 4'b0000, 12'd0);
        check_val("t5_no_rsp", 32'(rsp_valid_w[0]), 32'd0);
        step(1'b0, 4'b0010, {3'd0, 3'd0, 3'd7, 3'd0});
        step(1'b0, 4'b0000, 12'd0);
        step(1'b0, 4'b0000, 12'd0);
        check_val("t5_rsp_valid", 32'(rsp_valid_w[0]), 32'b0010);
        check_val("t5_rsp_data", 32'(rsp_data_w[0]), 32'h77);

        // latency-3 instance: busy T+1..T+3, response and new grant in T+4
        step(1'b1, 4'b0000, 12'd0);
        step(1'b0, 4'b0001, 12'd5);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0000, 12'd0);
            check_val($sformatf("t6_busy%0d", i + 1), 32'(busy_w[1]), 32'd1);
        end
        step(1'b0, 4'b0001, 12'd6);
        check_val("t6_rsp_valid", 32'(rsp_valid_w[1]), 32'b0001);
        check_val("t6_rsp_data", 32'(rsp_data_w[1]), 32'h55);
        check_val("t6_regrant", 32'(req_ready_w[1]), 32'b0001);
        check_val("t6_busy_resp", 32'(busy_w[1]), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 12'd0);

        // randomized traffic with occasional reset
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 39) == 0), 4'($urandom), 12'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
